// File: rtl/jpeg_enc_rle_packer.sv
// Run-length packer: 64 zigzag coefficients per block -> DC / AC / ZRL / EOB tokens.
// Optional token statistics counters are enabled by defining JPEG_ENC_RLE_STAT_EN.
module jpeg_enc_rle_packer (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        INIT,
  input  logic        CI_EN,
  input  logic [11:0] CI,
  output logic        CI_RDY,
  input  logic        BRST_AFULL,
  output logic        PO_EN,
  output logic [11:0] PO,
  output logic        PO_DC,
  output logic        PO_LST,
  output logic [3:0]  PO_ZR
`ifdef JPEG_ENC_RLE_STAT_EN
  ,
  output logic [15:0] STAT_BLK,
  output logic [15:0] STAT_ZRL
`endif
);

  typedef enum logic [1:0] {S_DC, S_AC, S_ZRL} state_t;

  state_t      state;
  logic [5:0]  idx;
  logic [5:0]  run;
  logic [1:0]  zrl;
  logic [11:0] lat_ci;
  logic [3:0]  lat_zr;
  logic        lat_lst;

  logic        xfer;
  logic        ci_nz;
  logic        last;

  logic        emit;
  logic [11:0] e_po;
  logic        e_dc;
  logic        e_lst;
  logic [3:0]  e_zr;
  logic        e_zrl;

  assign CI_RDY = ~BRST_AFULL & (state != S_ZRL) & ~INIT;
  assign xfer   = CI_EN & CI_RDY;
  assign ci_nz  = |CI;
  assign last   = (idx == 6'd63);

  // Token about to be emitted this cycle; shared by the output register and stat counters.
  always_comb begin
    emit  = 1'b0;
    e_po  = '0;
    e_dc  = 1'b0;
    e_lst = 1'b0;
    e_zr  = '0;
    e_zrl = 1'b0;
    case (state)
      S_DC: begin
        if (xfer) begin
          emit = 1'b1;
          e_po = CI;
          e_dc = 1'b1;
        end
      end
      S_AC: begin
        if (xfer) begin
          if (!ci_nz) begin
            if (last) begin
              emit  = 1'b1;
              e_lst = 1'b1;
            end
          end else if (run[5:4] == 2'd0) begin
            emit  = 1'b1;
            e_po  = CI;
            e_zr  = run[3:0];
            e_lst = last;
          end
        end
      end
      S_ZRL: begin
        if (!BRST_AFULL) begin
          emit = 1'b1;
          if (zrl != 2'd0) begin
            e_zr  = 4'hF;
            e_zrl = 1'b1;
          end else begin
            e_po  = lat_ci;
            e_zr  = lat_zr;
            e_lst = lat_lst;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_DC;
      idx     <= '0;
      run     <= '0;
      zrl     <= '0;
      lat_ci  <= '0;
      lat_zr  <= '0;
      lat_lst <= 1'b0;
      PO_EN   <= 1'b0;
      PO      <= '0;
      PO_DC   <= 1'b0;
      PO_LST  <= 1'b0;
      PO_ZR   <= '0;
    end else if (INIT) begin
      state   <= S_DC;
      idx     <= '0;
      run     <= '0;
      zrl     <= '0;
      lat_ci  <= '0;
      lat_zr  <= '0;
      lat_lst <= 1'b0;
      PO_EN   <= 1'b0;
      PO      <= '0;
      PO_DC   <= 1'b0;
      PO_LST  <= 1'b0;
      PO_ZR   <= '0;
    end else begin
      PO_EN <= emit;
      if (emit) begin
        PO     <= e_po;
        PO_DC  <= e_dc;
        PO_LST <= e_lst;
        PO_ZR  <= e_zr;
      end
      case (state)
        S_DC: begin
          if (xfer) begin
            idx   <= 6'd1;
            run   <= '0;
            state <= S_AC;
          end
        end
        S_AC: begin
          if (xfer) begin
            idx <= last ? 6'd0 : idx + 6'd1;
            if (!ci_nz) begin
              if (last) begin
                run   <= '0;
                state <= S_DC;
              end else begin
                run <= run + 6'd1;
              end
            end else if (run[5:4] == 2'd0) begin
              run <= '0;
              if (last) state <= S_DC;
            end else begin
              // Long run: park the level and expand run[5:4] ZRL tokens first.
              lat_ci  <= CI;
              lat_zr  <= run[3:0];
              lat_lst <= last;
              zrl     <= run[5:4];
              run     <= '0;
              state   <= S_ZRL;
            end
          end
        end
        S_ZRL: begin
          if (!BRST_AFULL) begin
            if (zrl != 2'd0) zrl <= zrl - 2'd1;
            else             state <= lat_lst ? S_DC : S_AC;
          end
        end
        default: state <= S_DC;
      endcase
    end
  end

`ifdef JPEG_ENC_RLE_STAT_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      STAT_BLK <= '0;
      STAT_ZRL <= '0;
    end else if (INIT) begin
      STAT_BLK <= '0;
      STAT_ZRL <= '0;
    end else begin
      if (emit && e_lst) STAT_BLK <= STAT_BLK + 16'd1;
      if (emit && e_zrl) STAT_ZRL <= STAT_ZRL + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jpeg_enc_rle_packer.sv
// Directed table-driven bench for jpeg_enc_rle_packer (token stream, CI_RDY, AFULL, INIT).
module tb_jpeg_enc_rle_packer;

  typedef struct packed {
    logic [11:0] po;
    logic        dc;
    logic        lst;
    logic [3:0]  zr;
  } tok_t;

  typedef logic [11:0] blk_t [64];

  typedef struct {
    logic [11:0] dc;
    int          pos;
    logic [11:0] val;
    bit          afull;
    int          n_tok;
    int          zrl_cnt;
    logic [3:0]  lvl_zr;
    bit          lvl_lst;
    int          rdy_low;
  } vec_t;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        INIT = 1'b0;
  logic        CI_EN = 1'b0;
  logic [11:0] CI = '0;
  logic        CI_RDY;
  logic        BRST_AFULL = 1'b0;
  logic        PO_EN;
  logic [11:0] PO;
  logic        PO_DC;
  logic        PO_LST;
  logic [3:0]  PO_ZR;
`ifdef JPEG_ENC_RLE_STAT_EN
  logic [15:0] STAT_BLK;
  logic [15:0] STAT_ZRL;
`endif

  jpeg_enc_rle_packer dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .INIT(INIT), .CI_EN(CI_EN), .CI(CI),
    .CI_RDY(CI_RDY), .BRST_AFULL(BRST_AFULL), .PO_EN(PO_EN), .PO(PO),
    .PO_DC(PO_DC), .PO_LST(PO_LST), .PO_ZR(PO_ZR)
`ifdef JPEG_ENC_RLE_STAT_EN
    , .STAT_BLK(STAT_BLK), .STAT_ZRL(STAT_ZRL)
`endif
  );

  always #5 HCLK = ~HCLK;

  int   checks = 0;
  int   failures = 0;
  tok_t rx[$];
  int   cyc = 0;
  int   first_cyc = -1;
  int   last_cyc = -1;
  int   rdy_low_cnt = 0;
  bit   chk_afull = 0;
  bit   afull_rand = 0;
  logic afull_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Token monitor plus the "no token while AFULL was high at the emitting edge" rule.
  always @(negedge HCLK) begin
    cyc++;
    if (!CI_RDY) rdy_low_cnt++;
    if (PO_EN) begin
      if (rx.size() == 0) first_cyc = cyc;
      last_cyc = cyc;
      rx.push_back({PO, PO_DC, PO_LST, PO_ZR});
      if (chk_afull) begin
        checks++;
        if (afull_prev) begin
          failures++;
          $display("FAIL afull_hold got=PO_EN exp=no_token cyc=%0d", cyc);
        end
      end
    end
    afull_prev = BRST_AFULL;
  end

  always @(posedge HCLK) begin
    if (afull_rand) begin
      #1;
      BRST_AFULL = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_block(input blk_t c);
    for (int i = 0; i < 64; i++) begin
      bit sent = 0;
      CI_EN = 1'b1;
      CI = c[i];
      for (int g = 0; g < 200 && !sent; g++) begin
        @(negedge HCLK);
        if (CI_RDY) sent = 1;
        @(posedge HCLK);
        #1;
      end
      if (!sent) begin
        chk($sformatf("xfer_timeout idx%0d", i), 32'd0, 32'd1);
        break;
      end
    end
    CI_EN = 1'b0;
    CI = '0;
  endtask

  task automatic wait_tokens(input int n);
    for (int g = 0; g < 400 && rx.size() < n; g++) @(negedge HCLK);
    if (rx.size() < n) chk("token_wait_timeout", rx.size(), n);
    repeat (4) @(negedge HCLK);
    @(posedge HCLK);
    #1;
  endtask

  task automatic run_case(input string nm, input blk_t c, input tok_t exp[$],
                          input int n_tok, input int rdy_exp, input bit afull);
    rx.delete();
    rdy_low_cnt = 0;
    if (afull) begin
      chk_afull = 1;
      afull_rand = 1;
    end
    send_block(c);
    if (afull) begin
      afull_rand = 0;
      @(posedge HCLK);
      #2;
      BRST_AFULL = 1'b0;
    end
    wait_tokens(n_tok);
    chk_afull = 0;
    chk({nm, " count"}, rx.size(), n_tok);
    for (int i = 0; i < exp.size() && i < rx.size(); i++)
      chk($sformatf("%s tok%0d", nm, i), 32'(rx[i]), 32'(exp[i]));
    if (rdy_exp >= 0) chk({nm, " rdy_low"}, rdy_low_cnt, rdy_exp);
  endtask

  vec_t vt[9];

  initial begin
    blk_t c;
    tok_t exp[$];

    //        dc      pos val    afull n  zrl zr    lst rdy
    vt[0] = '{12'hFFB, 0, 12'h000, 0, 2, 0, 4'd0,  0, 0};
    vt[1] = '{12'h000, 63, 12'h007, 0, 5, 3, 4'd14, 1, 4};
    vt[2] = '{12'h001, 16, 12'hFFD, 0, 3, 0, 4'd15, 0, 0};
    vt[3] = '{12'h002, 17, 12'h005, 0, 4, 1, 4'd0,  0, 2};
    vt[4] = '{12'h000, 1,  12'h7FF, 0, 3, 0, 4'd0,  0, 0};
    vt[5] = '{12'h800, 48, 12'hFFF, 0, 5, 2, 4'd15, 0, 3};
    vt[6] = '{12'h003, 32, 12'h123, 0, 4, 1, 4'd15, 0, 2};
    vt[7] = '{12'h006, 62, 12'h400, 0, 6, 3, 4'd13, 0, 4};
    vt[8] = '{12'h000, 63, 12'h007, 1, 5, 3, 4'd14, 1, -1};

    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst PO_EN", PO_EN, 0);
    chk("rst PO", PO, 0);
    chk("rst PO_DC", PO_DC, 0);
    chk("rst PO_LST", PO_LST, 0);
    chk("rst PO_ZR", PO_ZR, 0);
    chk("rst CI_RDY", CI_RDY, 1);
`ifdef JPEG_ENC_RLE_STAT_EN
    chk("rst STAT_BLK", STAT_BLK, 0);
    chk("rst STAT_ZRL", STAT_ZRL, 0);
`endif
    BRST_AFULL = 1'b1;
    #1;
    chk("afull CI_RDY", CI_RDY, 0);
    BRST_AFULL = 1'b0;
    @(posedge HCLK);
    #1;

    for (int v = 0; v < 9; v++) begin
      c = '{default: '0};
      c[0] = vt[v].dc;
      exp.delete();
      exp.push_back('{po: vt[v].dc, dc: 1'b1, lst: 1'b0, zr: 4'd0});
      if (vt[v].pos != 0) begin
        c[vt[v].pos] = vt[v].val;
        for (int z = 0; z < vt[v].zrl_cnt; z++)
          exp.push_back('{po: 12'h000, dc: 1'b0, lst: 1'b0, zr: 4'hF});
        exp.push_back('{po: vt[v].val, dc: 1'b0, lst: vt[v].lvl_lst, zr: vt[v].lvl_zr});
      end
      if (!(vt[v].pos != 0 && vt[v].lvl_lst))
        exp.push_back('{po: 12'h000, dc: 1'b0, lst: 1'b1, zr: 4'd0});
      run_case($sformatf("vec%0d", v), c, exp, vt[v].n_tok, vt[v].rdy_low, vt[v].afull);
    end

    // Two AC levels with short runs.
    c = '{default: '0};
    c[0] = 12'd100; c[1] = 12'd3; c[4] = 12'hFFF;
    exp.delete();
    exp.push_back('{po: 12'd100, dc: 1'b1, lst: 1'b0, zr: 4'd0});
    exp.push_back('{po: 12'd3,   dc: 1'b0, lst: 1'b0, zr: 4'd0});
    exp.push_back('{po: 12'hFFF, dc: 1'b0, lst: 1'b0, zr: 4'd2});
    exp.push_back('{po: 12'd0,   dc: 1'b0, lst: 1'b1, zr: 4'd0});
    run_case("two_ac", c, exp, 4, 0, 0);

    // Dense block: 64 tokens, no EOB, full rate.
    c = '{default: 12'd1};
    exp.delete();
    exp.push_back('{po: 12'd1, dc: 1'b1, lst: 1'b0, zr: 4'd0});
    for (int i = 1; i < 63; i++) exp.push_back('{po: 12'd1, dc: 1'b0, lst: 1'b0, zr: 4'd0});
    exp.push_back('{po: 12'd1, dc: 1'b0, lst: 1'b1, zr: 4'd0});
    run_case("all_ones", c, exp, 64, 0, 0);
    chk("all_ones span", last_cyc - first_cyc, 63);

    // INIT while a ZRL expansion is pending, then a fresh block.
    c = '{default: '0};
    c[0] = 12'd4; c[29] = 12'd2;
    for (int i = 0; i < 30; i++) begin
      CI_EN = 1'b1;
      CI = c[i];
      for (int g = 0; g < 20; g++) begin
        @(negedge HCLK);
        if (CI_RDY) begin
          @(posedge HCLK);
          #1;
          break;
        end
        @(posedge HCLK);
        #1;
      end
    end
    CI_EN = 1'b0;
    INIT = 1'b1;
    @(negedge HCLK);
    chk("init CI_RDY", CI_RDY, 0);
    @(posedge HCLK);
    #1;
    INIT = 1'b0;
    rx.delete();
    @(negedge HCLK);
    chk("init PO_EN", PO_EN, 0);
    chk("init PO", PO, 0);
    chk("init PO_ZR", PO_ZR, 0);
`ifdef JPEG_ENC_RLE_STAT_EN
    chk("init STAT_BLK", STAT_BLK, 0);
    chk("init STAT_ZRL", STAT_ZRL, 0);
`endif
    repeat (5) @(negedge HCLK);
    chk("init no_leak", rx.size(), 0);
    @(posedge HCLK);
    #1;
    c = '{default: '0};
    c[0] = 12'd9;
    exp.delete();
    exp.push_back('{po: 12'd9, dc: 1'b1, lst: 1'b0, zr: 4'd0});
    exp.push_back('{po: 12'd0, dc: 1'b0, lst: 1'b1, zr: 4'd0});
    run_case("post_init", c, exp, 2, 0, 0);
`ifdef JPEG_ENC_RLE_STAT_EN
    chk("post_init STAT_BLK", STAT_BLK, 1);
    chk("post_init STAT_ZRL", STAT_ZRL, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
